// File: rtl/pipe_ctrl.sv
// Pipeline control: stall-vector arbitration, one-cycle exception flush FSM,
// and a stall watchdog. Define PIPE_CTRL_PERF_CNT_EN to add the stall_cycles_o counter.
module pipe_ctrl #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        flush_req_i,
  input  logic [31:0] flush_pc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        timeout_o,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(STALL_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] stall_run;
  logic             stalled;

  // Zero-latency so a load-use bubble enters ID/EX on the same edge it is requested.
  always_comb begin
    stall = 6'b000000;
    if (state == RUN) begin
      if (stallreq_from_ex)      stall = 6'b001111;
      else if (stallreq_from_id) stall = 6'b000111;
    end
  end

  assign stalled = |stall;

  // flush_req_i is a single-cycle pulse with flush_pc_i qualified by it; there is
  // no back-pressure. A pulse arriving while already flushing is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      flush  <= 1'b0;
      new_pc <= 32'h0000_0000;
    end else begin
      case (state)
        RUN: begin
          if (flush_req_i) begin
            state  <= FLUSH;
            flush  <= 1'b1;
            new_pc <= flush_pc_i;
          end
        end
        FLUSH: begin
          state <= RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog observes only; stall_run saturates so a stuck stall never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_run <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (!stalled)                stall_run <= '0;
      else if (stall_run != RUN_MAX) stall_run <= stall_run + RUN_ONE;
      if (stalled && stall_run == RUN_LAST) timeout_o <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                perf_cnt <= 32'h0000_0000;
    else if (stalled && perf_cnt != 32'hFFFF_FFFF) perf_cnt <= perf_cnt + 32'd1;
  end

  assign stall_cycles_o = perf_cnt;
`else
  assign stall_cycles_o = 32'h0000_0000;
`endif

endmodule
